// File: rtl/stim_pkg.sv
// Shared types and sizing helpers for the serial stimulus driver.
package stim_pkg;

  localparam int unsigned DefWidth = 10;
  localparam int unsigned DefYw    = 2;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StDone = 2'd2
  } state_e;

  // Counter must hold values 0..w inclusive.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register; shifts left, zero fill, MSB tap.
module piso_shift #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] shreg_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q <= '0;
    end else if (load_i) begin
      shreg_q <= data_i;
    end else if (shift_i) begin
      shreg_q <= {shreg_q[WIDTH-2:0], 1'b0};
    end
  end

  assign msb_o = shreg_q[WIDTH-1];

endmodule

// File: rtl/serial_stim_driver.sv
// Shifts a parallel pattern out MSB-first onto x, captures y_in per bit and
// compares the final sample against a latched expected value.
module serial_stim_driver
  import stim_pkg::*;
#(
  parameter int unsigned WIDTH = DefWidth,
  parameter int unsigned YW    = DefYw,
  parameter int unsigned CW    = cnt_width(WIDTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic [WIDTH-1:0]    pattern,
  input  logic [CW-1:0]       len,
  input  logic [YW-1:0]       exp_y,
  input  logic [YW-1:0]       y_in,
  output logic                x,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic [YW*WIDTH-1:0] trace
);

  state_e              state_q;
  logic [CW-1:0]       cnt_q;
  logic [YW-1:0]       exp_q;
  logic [YW*WIDTH-1:0] trace_q;
  logic                match_q;
  logic                busy_q;
  logic                done_q;

  logic [CW-1:0]       len_eff;
  logic [WIDTH-1:0]    load_val;
  logic                load;
  logic                shift;
  logic                shreg_msb;

  assign len_eff  = (len > CW'(WIDTH)) ? CW'(WIDTH) : len;
  // Left-justify so bit [len-1] of the pattern sits at the MSB tap.
  assign load_val = pattern << (CW'(WIDTH) - len_eff);
  assign load     = (state_q == StIdle) && start && (len_eff != '0);
  assign shift    = (state_q == StSend) && !abort;

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_piso (
    .clk     (clk),
    .rst     (rst),
    .load_i  (load),
    .shift_i (shift),
    .data_i  (load_val),
    .msb_o   (shreg_msb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      exp_q   <= '0;
      trace_q <= '0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            cnt_q   <= len_eff;
            exp_q   <= exp_y;
            trace_q <= '0;
            if (len_eff == '0) begin
              state_q <= StDone;
              done_q  <= 1'b1;
              match_q <= 1'b1;
            end else begin
              state_q <= StSend;
              busy_q  <= 1'b1;
              match_q <= 1'b0;
            end
          end
        end
        StSend: begin
          // Abort wins over the final-bit transition and freezes the trace.
          if (abort) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else begin
            cnt_q   <= cnt_q - CW'(1);
            trace_q <= {trace_q[YW*WIDTH-YW-1:0], y_in};
            if (cnt_q == CW'(1)) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              match_q <= (y_in == exp_q);
            end
          end
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign x     = busy_q & shreg_msb;
  assign busy  = busy_q;
  assign done  = done_q;
  assign match = match_q;
  assign trace = trace_q;

endmodule

// File: tb/tb_serial_stim_driver.sv
// Table-driven and randomized checks of serial_stim_driver against a bit-level model.
module tb_serial_stim_driver;

  localparam int unsigned W  = 10;
  localparam int unsigned YW = 2;
  localparam int unsigned CW = 4;
  localparam int unsigned TW = YW * W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [W-1:0]  pattern = '0;
  logic [CW-1:0] len = '0;
  logic [YW-1:0] exp_y = '0;
  logic [YW-1:0] y_in = '0;
  logic          x, busy, done, match;
  logic [TW-1:0] trace;

  serial_stim_driver #(
    .WIDTH (W),
    .YW    (YW),
    .CW    (CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .abort   (abort),
    .pattern (pattern),
    .len     (len),
    .exp_y   (exp_y),
    .y_in    (y_in),
    .x       (x),
    .busy    (busy),
    .done    (done),
    .match   (match),
    .trace   (trace)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0]  pat;
    logic [CW-1:0] ln;
    logic [1:0]    ey;
    logic [TW-1:0] yv;       // sample k in bits [2k+1:2k]
    int            abort_at; // 0 = no abort, else bit index 1..len
    bit            noise;    // toggle start randomly while busy
    logic [TW-1:0] tr;
    bit            m;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Spec-level model: trace is the captured samples in order, newest lowest.
  function automatic void model(input logic [CW-1:0] ln, input logic [1:0] ey,
                                input logic [TW-1:0] yv, input int abort_at,
                                output logic [TW-1:0] tr, output bit m);
    int eff = (int'(ln) > W) ? W : int'(ln);
    int n   = (abort_at != 0 && abort_at <= eff) ? abort_at - 1 : eff;
    tr = '0;
    for (int k = 0; k < n; k++) tr = (tr << YW) | TW'(yv[k*YW +: YW]);
    if (eff == 0) m = 1'b1;
    else if (n < eff) m = 1'b0;
    else m = (yv[(eff-1)*YW +: YW] == ey);
  endfunction

  task automatic run_tx(input vec_t v);
    int eff = (int'(v.ln) > W) ? W : int'(v.ln);
    start   = 1'b1;
    pattern = v.pat;
    len     = v.ln;
    exp_y   = v.ey;
    step();
    start   = 1'b0;
    pattern = W'($urandom);
    len     = CW'($urandom);
    exp_y   = YW'($urandom);
    if (eff == 0) begin
      chk("len0_busy", 32'(busy), 32'd0);
      chk("len0_done", 32'(done), 32'd1);
      chk("len0_match", 32'(match), 32'd1);
      chk("len0_trace", 32'(trace), 32'd0);
      step();
      chk("len0_done_end", 32'(done), 32'd0);
      return;
    end
    for (int k = 1; k <= eff; k++) begin
      chk("send_busy", 32'(busy), 32'd1);
      chk("send_x", 32'(x), 32'(v.pat[eff-k]));
      chk("send_done", 32'(done), 32'd0);
      y_in = v.yv[(k-1)*YW +: YW];
      if (v.noise) start = 1'($urandom);
      if (k == v.abort_at) abort = 1'b1;
      step();
      if (k == v.abort_at) begin
        abort = 1'b0;
        start = 1'b0;
        chk("abort_x", 32'(x), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_trace", 32'(trace), 32'(v.tr));
        chk("abort_match", 32'(match), 32'd0);
        step();
        step();
        chk("abort_no_done", 32'(done), 32'd0);
        return;
      end
    end
    start = 1'b0;
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("end_x", 32'(x), 32'd0);
    chk("end_match", 32'(match), 32'(v.m));
    chk("end_trace", 32'(trace), 32'(v.tr));
    step();
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("match_held", 32'(match), 32'(v.m));
  endtask

  initial begin
    vec_t rv;
    vecs[0] = '{10'b0000011001, 4'd5, 2'b00, 20'({2'b00, 2'b11, 2'b10, 2'b10, 2'b01}),
                0, 1'b0, 20'h001AC, 1'b1};
    vecs[1] = '{10'b0000011001, 4'd5, 2'b11, 20'({2'b00, 2'b11, 2'b10, 2'b10, 2'b01}),
                0, 1'b1, 20'h001AC, 1'b0};
    vecs[2] = '{10'h155, 4'd0, 2'b10, 20'h0, 0, 1'b0, 20'h0, 1'b1};
    vecs[3] = '{10'h3FF, 4'd10, 2'b10, 20'hAAAAA, 0, 1'b0, 20'hAAAAA, 1'b1};
    vecs[4] = '{10'h0A5, 4'd8, 2'b00, 20'({2'b01, 2'b11}), 3, 1'b0, 20'h0000D, 1'b0};
    vecs[5] = '{10'h2A5, 4'd15, 2'b01, 20'h55555, 0, 1'b1, 20'h55555, 1'b1};
    vecs[6] = '{10'h001, 4'd1, 2'b11, 20'h00003, 0, 1'b0, 20'h00003, 1'b1};

    #2;
    chk("rst_x", 32'(x), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    #28 rst = 1'b0;
    step();
    chk("post_rst_x", 32'(x), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_done", 32'(done), 32'd0);
    chk("post_rst_trace", 32'(trace), 32'd0);
    chk("post_rst_match", 32'(match), 32'd0);

    foreach (vecs[i]) run_tx(vecs[i]);

    // start held high: second send begins only after DONE -> IDLE
    start   = 1'b1;
    pattern = 10'b101;
    len     = 4'd3;
    exp_y   = 2'b00;
    y_in    = 2'b00;
    step();
    for (int k = 1; k <= 3; k++) begin
      chk("hold_busy", 32'(busy), 32'd1);
      chk("hold_x", 32'(x), (k == 2) ? 32'd0 : 32'd1);
      step();
    end
    chk("hold_done", 32'(done), 32'd1);
    step();
    chk("hold_idle_busy", 32'(busy), 32'd0);
    chk("hold_idle_done", 32'(done), 32'd0);
    step();
    chk("hold_second_busy", 32'(busy), 32'd1);
    chk("hold_second_x", 32'(x), 32'd1);
    start = 1'b0;
    repeat (4) step();
    chk("hold_final_busy", 32'(busy), 32'd0);
    chk("hold_final_done", 32'(done), 32'd0);

    // asynchronous reset in the middle of a send
    start   = 1'b1;
    pattern = 10'h3FF;
    len     = 4'd8;
    y_in    = 2'b11;
    step();
    start = 1'b0;
    step();
    step();
    chk("pre_rst_trace", 32'(trace), 32'h0000F);
    #3 rst = 1'b1;
    #1;
    chk("midrst_x", 32'(x), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_trace", 32'(trace), 32'd0);
    chk("midrst_match", 32'(match), 32'd0);
    #10 rst = 1'b0;
    step();
    step();
    chk("after_rst_busy", 32'(busy), 32'd0);
    chk("after_rst_done", 32'(done), 32'd0);

    for (int it = 0; it < 40; it++) begin
      rv.pat      = W'($urandom);
      rv.ln       = CW'($urandom_range(0, 12));
      rv.yv       = TW'($urandom);
      rv.ey       = ($urandom_range(0, 1) == 1) ? YW'($urandom) : rv.yv[YW-1:0];
      rv.abort_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : 0;
      rv.noise    = 1'($urandom);
      if (rv.ln >= 1 && int'(rv.ln) <= W && $urandom_range(0, 1) == 1)
        rv.ey = rv.yv[(int'(rv.ln) - 1)*YW +: YW];
      model(rv.ln, rv.ey, rv.yv, rv.abort_at, rv.tr, rv.m);
      run_tx(rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
